// File: rtl/hash160_pkg.sv
// Shared types and constants for the Hash160 (SHA-256 digest -> RIPEMD-160) scheduler.
package hash160_pkg;

  localparam int unsigned DIGEST_W = 256;
  localparam int unsigned HASH_W   = 160;
  localparam int unsigned BLOCK_W  = 512;

  localparam logic [31:0] PAD_WORD8  = 32'h00000080;
  localparam logic [31:0] LEN_WORD14 = 32'h00000100;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/ripemd_pad.sv
// Builds the single padded RIPEMD-160 block for a 256-bit message (little-endian words).
module ripemd_pad
  import hash160_pkg::*;
(
  input  logic [DIGEST_W-1:0] digest,
  output logic [BLOCK_W-1:0]  block
);

  // Message byte k sits at digest[255-8k -: 8]; byte 4i+j lands in word i, byte lane j.
  always_comb begin
    block = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        block[32*i + 8*j +: 8] = digest[DIGEST_W - 1 - 8*(4*i + j) -: 8];
      end
    end
    block[32*8  +: 32] = PAD_WORD8;
    block[32*14 +: 32] = LEN_WORD14;
  end

endmodule

// File: rtl/ripemd_sched.sv
// Two-requester round-robin front end that pads a digest, runs the RIPEMD-160 core and returns the result.
module ripemd_sched
  import hash160_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  output logic                req0_ready,
  input  logic [DIGEST_W-1:0] req0_data,
  input  logic                req1_valid,
  output logic                req1_ready,
  input  logic [DIGEST_W-1:0] req1_data,
  output logic                core_valid,
  output logic [BLOCK_W-1:0]  core_block,
  input  logic [HASH_W-1:0]   core_ans,
  input  logic                core_done,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [HASH_W-1:0]   resp_digest,
  output logic                resp_id,
  output logic                resp_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  state_t               state, state_n;
  logic                 last_grant, grant, any_req, accept;
  logic                 done_q, done_edge, timed_out;
  logic [CW-1:0]        cnt;
  logic [DIGEST_W-1:0]  sel_data;
  logic [BLOCK_W-1:0]   pad_block;

  ripemd_pad u_pad (
    .digest (sel_data),
    .block  (pad_block)
  );

  always_comb begin
    any_req = req0_valid | req1_valid;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = ~req0_valid;
    sel_data  = grant ? req1_data : req0_data;
    done_edge = core_done & ~done_q;
    timed_out = (cnt == CW'(TIMEOUT - 1));
  end

  always_comb begin
    state_n    = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    core_valid = 1'b0;
    resp_valid = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        req0_ready = any_req & ~grant;
        req1_ready = any_req & grant;
        if (any_req) begin
          accept  = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        core_valid = 1'b1;
        state_n    = WAIT;
      end
      WAIT: begin
        if (done_edge || timed_out) state_n = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      done_q      <= 1'b0;
      cnt         <= '0;
      core_block  <= '0;
      resp_digest <= '0;
      resp_err    <= 1'b0;
      resp_id     <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= core_done;
      if (accept) begin
        last_grant <= grant;
        resp_id    <= grant;
        core_block <= pad_block;
      end
      if (state == ISSUE) cnt <= '0;
      if (state == WAIT) begin
        cnt <= cnt + CW'(1);
        // A completion edge takes priority over a coincident timeout.
        if (done_edge || timed_out) begin
          core_block  <= '0;
          resp_digest <= done_edge ? core_ans : '0;
          resp_err    <= ~done_edge;
        end
      end
    end
  end

endmodule

// File: tb/tb_ripemd_sched.sv
// Directed bench for ripemd_sched with TIMEOUT = 8.
module tb_ripemd_sched;
  import hash160_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                req0_valid = 1'b0, req1_valid = 1'b0;
  logic                req0_ready, req1_ready;
  logic [DIGEST_W-1:0] req0_data = '0, req1_data = '0;
  logic                core_valid;
  logic [BLOCK_W-1:0]  core_block;
  logic [HASH_W-1:0]   core_ans = '0;
  logic                core_done = 1'b0;
  logic                resp_valid;
  logic                resp_ready = 1'b0;
  logic [HASH_W-1:0]   resp_digest;
  logic                resp_id, resp_err;

  int total = 0;
  int bad   = 0;
  int rdy0_n = 0, rdy1_n = 0;
  logic cnt_en = 1'b0;

  localparam logic [DIGEST_W-1:0] DATA_A = {8{32'h11223344}};
  localparam logic [DIGEST_W-1:0] DATA_B = {8{32'hdeadbeef}};
  localparam logic [HASH_W-1:0]   ANS0 = 160'h0123456789abcdef0123456789abcdef01234567;
  localparam logic [HASH_W-1:0]   ANS1 = 160'hfedcba9876543210fedcba9876543210fedcba98;
  localparam logic [HASH_W-1:0]   ANS2 = 160'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0_12345678;
  localparam logic [HASH_W-1:0]   ANS3 = 160'hcafebabe_00000001_80000000_13579bdf_2468ace0;

  ripemd_sched #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .core_valid(core_valid), .core_block(core_block),
    .core_ans(core_ans), .core_done(core_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_digest(resp_digest), .resp_id(resp_id), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cnt_en) begin
      rdy0_n += int'(req0_ready);
      rdy1_n += int'(req1_ready);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    total++; if (core_valid !== 1'b0) begin bad++; $display("FAIL reset_core_valid got=%b exp=0", core_valid); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    total++; if ({resp_err, resp_id} !== 2'b00) begin bad++; $display("FAIL reset_err_id got=%b exp=00", {resp_err, resp_id}); end
    total++; if (resp_digest !== '0) begin bad++; $display("FAIL reset_digest got=%h exp=0", resp_digest); end
    total++; if (core_block !== '0) begin bad++; $display("FAIL reset_block got=%h exp=0", core_block); end
    total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
    rst = 1'b0;
  endtask

  task automatic test_padding;
    logic [DIGEST_W-1:0] d;
    logic [31:0] expw [16];
    for (int k = 0; k < 32; k++) d[255 - 8*k -: 8] = 8'(k);
    for (int i = 0; i < 16; i++) expw[i] = 32'h0;
    expw[0] = 32'h03020100; expw[1] = 32'h07060504; expw[2] = 32'h0b0a0908; expw[3] = 32'h0f0e0d0c;
    expw[4] = 32'h13121110; expw[5] = 32'h17161514; expw[6] = 32'h1b1a1918; expw[7] = 32'h1f1e1d1c;
    expw[8] = 32'h00000080; expw[14] = 32'h00000100;
    req0_data = d; req0_valid = 1'b1; #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL pad_ready got=%b exp=10", {req0_ready, req1_ready}); end
    tick(); req0_valid = 1'b0;
    total++; if (core_valid !== 1'b1) begin bad++; $display("FAIL pad_issue_valid got=%b exp=1", core_valid); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (core_block[32*i +: 32] !== expw[i]) begin
        bad++; $display("FAIL pad_word%0d got=%h exp=%h", i, core_block[32*i +: 32], expw[i]);
      end
    end
    tick();
    total++; if (core_valid !== 1'b0) begin bad++; $display("FAIL pad_valid_pulse got=%b exp=0", core_valid); end
    total++; if (core_block[31:0] !== 32'h03020100) begin bad++; $display("FAIL pad_block_held got=%h exp=03020100", core_block[31:0]); end
    core_done = 1'b1; core_ans = ANS0;
    tick(); core_done = 1'b0;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL pad_resp_valid got=%b exp=1", resp_valid); end
    total++; if (resp_digest !== ANS0) begin bad++; $display("FAIL pad_resp_digest got=%h exp=%h", resp_digest, ANS0); end
    total++; if ({resp_err, resp_id} !== 2'b00) begin bad++; $display("FAIL pad_err_id got=%b exp=00", {resp_err, resp_id}); end
    total++; if (core_block !== '0) begin bad++; $display("FAIL pad_block_cleared got=%h exp=0", core_block); end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL pad_resp_release got=%b exp=0", resp_valid); end
  endtask

  task automatic test_tie;
    rst = 1'b1; tick(); rst = 1'b0;
    rdy0_n = 0; rdy1_n = 0; cnt_en = 1'b1;
    req0_data = DATA_A; req1_data = DATA_B;
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL tie_first_grant got=%b exp=10", {req0_ready, req1_ready}); end
    tick(); req0_valid = 1'b0; #1;
    total++; if (req1_ready !== 1'b0) begin bad++; $display("FAIL tie_busy_ready got=%b exp=0", req1_ready); end
    total++; if (core_block[31:0] !== 32'h44332211) begin bad++; $display("FAIL tie_block_a got=%h exp=44332211", core_block[31:0]); end
    tick();
    core_done = 1'b1; core_ans = ANS0;
    tick(); core_done = 1'b0;
    total++; if ({resp_valid, resp_id} !== 2'b10) begin bad++; $display("FAIL tie_resp0 got=%b exp=10", {resp_valid, resp_id}); end
    total++; if (resp_digest !== ANS0) begin bad++; $display("FAIL tie_digest0 got=%h exp=%h", resp_digest, ANS0); end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0; #1;
    total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL tie_second_grant got=%b exp=01", {req0_ready, req1_ready}); end
    tick(); req1_valid = 1'b0;
    total++; if (core_block[31:0] !== 32'hefbeadde) begin bad++; $display("FAIL tie_block_b got=%h exp=efbeadde", core_block[31:0]); end
    tick();
    core_done = 1'b1; core_ans = ANS1;
    tick(); core_done = 1'b0;
    total++; if ({resp_valid, resp_id} !== 2'b11) begin bad++; $display("FAIL tie_resp1 got=%b exp=11", {resp_valid, resp_id}); end
    total++; if (resp_digest !== ANS1) begin bad++; $display("FAIL tie_digest1 got=%h exp=%h", resp_digest, ANS1); end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    cnt_en = 1'b0;
    total++; if (rdy0_n !== 1) begin bad++; $display("FAIL tie_ready0_pulses got=%0d exp=1", rdy0_n); end
    total++; if (rdy1_n !== 1) begin bad++; $display("FAIL tie_ready1_pulses got=%0d exp=1", rdy1_n); end
  endtask

  task automatic test_timeout;
    req1_data = DATA_B; req1_valid = 1'b1;
    tick(); req1_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      total++;
      if (resp_valid !== (i == 10)) begin
        bad++; $display("FAIL timeout_latency cycle=%0d got=%b exp=%b", i, resp_valid, (i == 10));
      end
      if (i < 10) tick();
    end
    total++; if ({resp_err, resp_id} !== 2'b11) begin bad++; $display("FAIL timeout_err_id got=%b exp=11", {resp_err, resp_id}); end
    total++; if (resp_digest !== '0) begin bad++; $display("FAIL timeout_digest got=%h exp=0", resp_digest); end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
  endtask

  task automatic test_stale_done;
    core_done = 1'b1; core_ans = ANS2;
    tick();
    req0_data = DATA_A; req0_valid = 1'b1;
    tick(); req0_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      total++;
      if (resp_valid !== (i == 10)) begin
        bad++; $display("FAIL stale_latency cycle=%0d got=%b exp=%b", i, resp_valid, (i == 10));
      end
      if (i < 10) tick();
    end
    total++; if (resp_err !== 1'b1) begin bad++; $display("FAIL stale_err got=%b exp=1", resp_err); end
    total++; if (resp_digest !== '0) begin bad++; $display("FAIL stale_digest got=%h exp=0", resp_digest); end
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
    req0_valid = 1'b1;
    tick(); req0_valid = 1'b0;
    tick(); tick();
    core_done = 1'b0;
    tick();
    core_done = 1'b1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL stale_early_resp got=%b exp=0", resp_valid); end
    tick();
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL stale_edge_resp got=%b exp=1", resp_valid); end
    total++; if (resp_err !== 1'b0) begin bad++; $display("FAIL stale_edge_err got=%b exp=0", resp_err); end
    total++; if (resp_digest !== ANS2) begin bad++; $display("FAIL stale_edge_digest got=%h exp=%h", resp_digest, ANS2); end
    core_done = 1'b0;
    resp_ready = 1'b1; tick(); resp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    req0_data = DATA_A; req0_valid = 1'b1;
    tick(); req0_valid = 1'b0;
    tick();
    core_done = 1'b1; core_ans = ANS3;
    tick(); core_done = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid cycle=%0d got=%b exp=1", i, resp_valid); end
      total++; if (resp_digest !== ANS3) begin bad++; $display("FAIL bp_digest cycle=%0d got=%h exp=%h", i, resp_digest, ANS3); end
      total++; if ({req0_ready, req1_ready} !== 2'b00) begin bad++; $display("FAIL bp_ready cycle=%0d got=%b exp=00", i, {req0_ready, req1_ready}); end
      tick();
    end
    resp_ready = 1'b1;
    tick(); resp_ready = 1'b0; #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", resp_valid); end
    total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL bp_idle_rr got=%b exp=01", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset_in_wait;
    req1_data = DATA_B; req1_valid = 1'b1;
    tick(); req1_valid = 1'b0;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if ({core_valid, resp_valid, resp_err, resp_id} !== 4'b0000) begin bad++; $display("FAIL rstw_flags got=%b exp=0000", {core_valid, resp_valid, resp_err, resp_id}); end
    total++; if (resp_digest !== '0) begin bad++; $display("FAIL rstw_digest got=%h exp=0", resp_digest); end
    total++; if (core_block !== '0) begin bad++; $display("FAIL rstw_block got=%h exp=0", core_block); end
    core_done = 1'b1; core_ans = ANS1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if ({resp_valid, core_valid} !== 2'b00) begin bad++; $display("FAIL rstw_ignore_done cycle=%0d got=%b exp=00", i, {resp_valid, core_valid}); end
    end
    core_done = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL rstw_tie got=%b exp=10", {req0_ready, req1_ready}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_padding();
    test_tie();
    test_timeout();
    test_stale_done();
    test_backpressure();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ripemd_sched.md
RIPEMD_SCHED -- requirements
Module: ripemd_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, the maximum number of cycles to wait for the core to finish.
REQ-002 SHALL have a single clock `clk` and a synchronous, active-high reset `rst`.
REQ-003 SHALL provide these ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has a digest to hash.
- req0_ready  out  1  requester 0 digest is accepted this cycle.
- req0_data  in  256  requester 0 SHA-256 digest; byte0 = [255:248].
- req1_valid  in  1  same meaning as req0_valid, for requester 1.
- req1_ready  out  1  same meaning as req0_ready, for requester 1.
- req1_data  in  256  same meaning as req0_data, for requester 1.
- core_valid  out  1  start pulse to the RIPEMD-160 core's i_valid.
- core_block  out  512  padded block to the core; word i = bits [32i+31:32i].
- core_ans  in  160  core result.
- core_done  in  1  core o_valid, level or pulse.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts the result.
- resp_digest  out  160  Hash160 result.
- resp_id  out  1  requester the result belongs to.
- resp_err  out  1  core timed out.

Function
REQ-004 SHALL implement the states IDLE, ISSUE, WAIT and RESP.
REQ-005 In IDLE, arbitration SHALL be:
- grant = the single valid requester;
- if both are valid, grant the one not granted last (round-robin);
- reqX_ready = 1 only in IDLE, only for the granted X, combinationally;
- on a handshake, capture the data and id, then go to ISSUE.
REQ-006 core_block SHALL be built from the captured digest as follows:
- words 0..7 = {b[4i+3], b[4i+2], b[4i+1], b[4i]};
- word8 = 0x00000080;
- words 9..13 = 0;
- word14 = 0x00000100 (256-bit length);
- word15 = 0.
REQ-007 core_block SHALL be registered and held stable from ISSUE until leaving WAIT; it SHALL be 0 otherwise.
REQ-008 ISSUE SHALL assert core_valid for exactly one cycle, then go to WAIT.
REQ-009 WAIT SHALL detect completion and timeout as follows:
- completion is a rising edge of core_done, sampled against a registered copy of its previous value;
- a core_done level already high on entry SHALL NOT count;
- a cycle counter starts at 0 on entry.
REQ-010 On a core_done rising edge, the block SHALL latch core_ans into resp_digest, set resp_err = 0 and go to RESP.
REQ-011 When the counter reaches TIMEOUT without a core_done edge, the block SHALL set resp_digest = 0, set resp_err = 1 and go to RESP.
REQ-012 If a core_done edge and the timeout occur in the same cycle, completion SHALL win.
REQ-013 RESP SHALL hold resp_valid = 1 with resp_digest, resp_id and resp_err stable until resp_ready is 1; on that handshake it SHALL go to IDLE.
REQ-014 No request SHALL be accepted outside IDLE, and the earliest new acceptance is the cycle after the RESP handshake.
REQ-015 Latency from request handshake to resp_valid SHALL be 2 + N cycles, where N is the number of WAIT cycles.
REQ-016 The last-grant register SHALL update only on a request handshake.

Reset
REQ-017 When rst = 1 at a clk edge, the block SHALL:
- enter IDLE;
- drive core_valid, resp_valid, resp_err, resp_id, req0_ready/req1_ready registers, resp_digest and core_block to 0;
- clear the counter and the prior-done register;
- set last grant = 1, so req0 wins the first tie.
REQ-018 Reset during ISSUE, WAIT or RESP SHALL abandon the operation with no response, and any later core_done SHALL be ignored unless the block is in WAIT.

Structure
REQ-019 Package hash160_pkg SHALL hold:
- the state enum;
- DIGEST_W = 256 and HASH_W = 160;
- PAD_WORD8 = 32'h00000080 and LEN_WORD14 = 32'h00000100.
REQ-020 The padding SHALL be a separate combinational sub-module, ripemd_pad (256-bit in, 512-bit out); arbitration and the FSM SHALL stay in ripemd_sched.

Verification
REQ-021 Padding: req0_data = 0x000102…1f -> core_block word0 = 0x03020100, word7 = 0x1f1e1d1c, word8 = 0x80, word14 = 0x100, all other words 0.
REQ-022 Tie after reset: req0 and req1 valid together -> req0 served first (resp_id = 0), then req1 (resp_id = 1); each sees exactly one ready pulse.
REQ-023 Timeout: TIMEOUT = 8 and core_done held 0 -> resp_valid rises 10 cycles after the handshake with resp_err = 1 and resp_digest = 0.
REQ-024 Stale done: core_done high before ISSUE and held high -> no completion is accepted; the timeout is reported; a later 0->1 edge instead yields resp_err = 0 with core_ans latched.
REQ-025 Backpressure: resp_ready held 0 for 5 cycles -> resp_valid and resp_digest stay stable, both readys stay 0, and IDLE is re-entered the cycle after resp_ready = 1.
REQ-026 Reset in WAIT: rst asserted mid-WAIT -> next cycle IDLE, all outputs 0, and no resp_valid even if core_done rises afterward.
